// File: rtl/audio_sched_pkg.sv
// ----------------------------------------------------------------------------
// audio_sched_pkg
// Shared types and constants for the audio playback scheduler.
//   state_e       : scheduler FSM states.
//   DEFAULT_SEL_W : default clip-select width (matches the Audio block).
// ----------------------------------------------------------------------------
package audio_sched_pkg;

    localparam int unsigned DEFAULT_SEL_W = 3;

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StWaitLow,
        StPlay,
        StGap
    } state_e;

endpackage

// File: rtl/rr_picker.sv
// ----------------------------------------------------------------------------
// rr_picker
// Combinational round-robin selector. Searches the pending vector starting at
// the pointer and wrapping at NUM_REQ; returns the first set index.
//   i_pend  : pending flags, one per requester
//   i_ptr   : search start index
//   o_idx   : winning requester index (valid only when o_valid)
//   o_valid : at least one requester pending
// ----------------------------------------------------------------------------
module rr_picker
    import audio_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_pend,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_valid
);

    always_comb begin
        int unsigned k;
        k       = 0;
        o_idx   = '0;
        o_valid = 1'b0;
        // Walk from the farthest offset down so the nearest pending one wins.
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            k = (int'(i_ptr) + off) % NUM_REQ;
            if (i_pend[k[IDX_W-1:0]]) begin
                o_idx   = k[IDX_W-1:0];
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/audio_play_scheduler.sv
// ----------------------------------------------------------------------------
// audio_play_scheduler
// Shares one Audio playback block between NUM_REQ requesters. Latches one
// pending clip per requester, launches them round-robin, waits for the
// block's audioEnd, then inserts a silence gap before the next clip.
//   i_clk, i_rst     : clock, synchronous active-high reset
//   i_req, i_req_sel : request strobes and packed per-requester clip selects
//   o_grant, o_done  : one-hot pulses on clip launch / clip finish or abort
//   o_busy           : scheduler not idle
//   o_timeout        : sticky watchdog abort flag
//   o_audio_enable, o_audio_select, i_audio_end : Audio block handshake
// Optional: define AUDIO_SCHED_WATCHDOG_EN to abort clips whose audioEnd
// never arrives within TIMEOUT_CYCLES; otherwise o_timeout is tied low.
// ----------------------------------------------------------------------------
module audio_play_scheduler
    import audio_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned SEL_W          = DEFAULT_SEL_W,
    parameter int unsigned GAP_CYCLES     = 1000,
    parameter int unsigned TIMEOUT_CYCLES = 400_000_000
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [NUM_REQ-1:0]       i_req,
    input  logic [NUM_REQ*SEL_W-1:0] i_req_sel,
    output logic [NUM_REQ-1:0]       o_grant,
    output logic [NUM_REQ-1:0]       o_done,
    output logic                     o_busy,
    output logic                     o_timeout,
    output logic                     o_audio_enable,
    output logic [SEL_W-1:0]         o_audio_select,
    input  logic                     i_audio_end
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);

    state_e             r_state;
    logic [NUM_REQ-1:0] r_pend;
    logic [SEL_W-1:0]   r_pend_sel [NUM_REQ];
    logic [IDX_W-1:0]   r_rr;
    logic [IDX_W-1:0]   r_win;
    logic [GAP_W-1:0]   r_gap_cnt;
    logic               r_end_s1;
    logic               r_end_s2;
    logic [NUM_REQ-1:0] r_grant;
    logic [NUM_REQ-1:0] r_done;
    logic               r_busy;
    logic               r_audio_enable;
    logic [SEL_W-1:0]   r_audio_select;

    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_pick_valid;
    logic [NUM_REQ-1:0] w_win_onehot;
    logic               w_launch;

    assign w_win_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_win;
    assign w_launch     = (r_state == StLaunch);

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_picker (
        .i_pend  (r_pend),
        .i_ptr   (r_rr),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

    // audioEnd comes from another timing domain.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_end_s1 <= 1'b0;
            r_end_s2 <= 1'b0;
        end else begin
            r_end_s1 <= i_audio_end;
            r_end_s2 <= r_end_s1;
        end
    end

    // Pending table: a new request beats a same-cycle launch clear.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pend <= '0;
            for (int i = 0; i < NUM_REQ; i++) r_pend_sel[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (i_req[i]) begin
                    r_pend[i]     <= 1'b1;
                    r_pend_sel[i] <= i_req_sel[i*SEL_W +: SEL_W];
                end else if (w_launch && (r_win == IDX_W'(i))) begin
                    r_pend[i] <= 1'b0;
                end
            end
        end
    end

`ifdef AUDIO_SCHED_WATCHDOG_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] r_wd_cnt;
    logic            r_timeout;
    logic            w_wd_expired;
    assign w_wd_expired = (r_wd_cnt >= WD_W'(TIMEOUT_CYCLES - 1));
    assign o_timeout    = r_timeout;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
    assign o_timeout        = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= StIdle;
            r_rr           <= '0;
            r_win          <= '0;
            r_gap_cnt      <= '0;
            r_grant        <= '0;
            r_done         <= '0;
            r_busy         <= 1'b0;
            r_audio_enable <= 1'b0;
            r_audio_select <= '0;
`ifdef AUDIO_SCHED_WATCHDOG_EN
            r_wd_cnt       <= '0;
            r_timeout      <= 1'b0;
`endif
        end else begin
            r_grant <= '0;
            r_done  <= '0;
            unique case (r_state)
                StIdle: begin
                    if (w_pick_valid) begin
                        r_win          <= w_pick_idx;
                        r_audio_select <= r_pend_sel[w_pick_idx];
                        r_busy         <= 1'b1;
                        r_state        <= StLaunch;
                    end
                end
                StLaunch: begin
                    r_audio_enable <= 1'b1;
                    r_grant        <= w_win_onehot;
                    r_rr           <= (r_win == IDX_W'(NUM_REQ - 1)) ? '0 : r_win + 1'b1;
                    r_state        <= StWaitLow;
`ifdef AUDIO_SCHED_WATCHDOG_EN
                    r_wd_cnt       <= '0;
`endif
                end
                StWaitLow: begin
                    // Block has acknowledged the start once audioEnd drops.
                    if (!r_end_s2) r_state <= StPlay;
`ifdef AUDIO_SCHED_WATCHDOG_EN
                    if (w_wd_expired) begin
                        r_audio_enable <= 1'b0;
                        r_done         <= w_win_onehot;
                        r_timeout      <= 1'b1;
                        r_gap_cnt      <= '0;
                        r_state        <= StGap;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + 1'b1;
                    end
`endif
                end
                StPlay: begin
                    if (r_end_s2) begin
                        r_audio_enable <= 1'b0;
                        r_done         <= w_win_onehot;
                        r_gap_cnt      <= '0;
                        r_state        <= StGap;
                    end
`ifdef AUDIO_SCHED_WATCHDOG_EN
                    else if (w_wd_expired) begin
                        r_audio_enable <= 1'b0;
                        r_done         <= w_win_onehot;
                        r_timeout      <= 1'b1;
                        r_gap_cnt      <= '0;
                        r_state        <= StGap;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + 1'b1;
                    end
`endif
                end
                StGap: begin
                    // Stays GAP_CYCLES+1 cycles; counter stops at its limit.
                    if (r_gap_cnt >= GAP_W'(GAP_CYCLES)) begin
                        r_busy  <= 1'b0;
                        r_state <= StIdle;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_grant        = r_grant;
    assign o_done         = r_done;
    assign o_busy         = r_busy;
    assign o_audio_enable = r_audio_enable;
    assign o_audio_select = r_audio_select;

endmodule

// File: tb/tb_audio_play_scheduler.sv
// ----------------------------------------------------------------------------
// tb_audio_play_scheduler
// Scoreboard bench: stimulus pushes expected grants/dones, a monitor pops and
// compares whenever the DUT pulses grant or done.
// ----------------------------------------------------------------------------
module tb_audio_play_scheduler;

    localparam int unsigned NUM_REQ  = 4;
    localparam int unsigned SEL_W    = 3;
    localparam int unsigned GAP      = 4;
    localparam int unsigned TIMEOUT  = 100;
    localparam int unsigned PLAY_LEN = 8;

    logic                     clk = 1'b0;
    logic                     i_rst = 1'b1;
    logic [NUM_REQ-1:0]       i_req = '0;
    logic [NUM_REQ*SEL_W-1:0] i_req_sel = '0;
    logic                     i_audio_end = 1'b1;
    logic [NUM_REQ-1:0]       o_grant;
    logic [NUM_REQ-1:0]       o_done;
    logic                     o_busy;
    logic                     o_timeout;
    logic                     o_audio_enable;
    logic [SEL_W-1:0]         o_audio_select;

    audio_play_scheduler #(
        .NUM_REQ        (NUM_REQ),
        .SEL_W          (SEL_W),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .i_clk          (clk),
        .i_rst          (i_rst),
        .i_req          (i_req),
        .i_req_sel      (i_req_sel),
        .o_grant        (o_grant),
        .o_done         (o_done),
        .o_busy         (o_busy),
        .o_timeout      (o_timeout),
        .o_audio_enable (o_audio_enable),
        .o_audio_select (o_audio_select),
        .i_audio_end    (i_audio_end)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NUM_REQ-1:0] oh;
        logic [SEL_W-1:0]   sel;
    } exp_t;

    exp_t               grant_q[$];
    logic [NUM_REQ-1:0] done_q[$];
    int                 n_checks = 0;
    int                 n_errors = 0;
    int                 g_grant_cnt = 0;
    bit                 g_auto = 1'b0;
    bit                 g_hang = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_clip(input int idx, input int sel, input bit with_done);
        exp_t e;
        e.oh  = NUM_REQ'(1) << idx;
        e.sel = SEL_W'(sel);
        grant_q.push_back(e);
        if (with_done) done_q.push_back(e.oh);
    endtask

    task automatic do_reset();
        @(negedge clk);
        i_rst = 1'b1;
        i_req = '0;
        repeat (2) @(negedge clk);
        i_rst = 1'b0;
    endtask

    task automatic wait_grants(input int target, input int budget);
        int n = 0;
        while (g_grant_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("wait_grants", 32'(g_grant_cnt >= target), 1);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((o_busy || grant_q.size() != 0 || done_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle", 32'(n < budget), 1);
    endtask

    // Monitor / scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (o_grant != '0) begin
                g_grant_cnt++;
                if (grant_q.size() == 0) begin
                    check("grant_unexpected", 32'(o_grant), 0);
                end else begin
                    e = grant_q.pop_front();
                    check("grant_onehot", 32'(o_grant), 32'(e.oh));
                    check("grant_select", 32'(o_audio_select), 32'(e.sel));
                    check("grant_enable", 32'(o_audio_enable), 1);
                end
            end
            if (o_done != '0) begin
                if (done_q.size() == 0) begin
                    check("done_unexpected", 32'(o_done), 0);
                end else begin
                    check("done_onehot", 32'(o_done), 32'(done_q.pop_front()));
                    check("done_enable_low", 32'(o_audio_enable), 0);
                end
            end
        end
    end

    // Audio block model: acks start, plays PLAY_LEN cycles, raises audioEnd.
    initial begin
        forever begin
            @(posedge o_audio_enable);
            if (g_auto) begin
                repeat (2) @(negedge clk);
                i_audio_end = 1'b0;
                if (!g_hang) begin
                    repeat (PLAY_LEN) @(negedge clk);
                    i_audio_end = 1'b1;
                end
            end
        end
    end

    initial begin
        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_grant", 32'(o_grant), 0);
        check("rst_done", 32'(o_done), 0);
        check("rst_busy", 32'(o_busy), 0);
        check("rst_timeout", 32'(o_timeout), 0);
        check("rst_enable", 32'(o_audio_enable), 0);
        check("rst_select", 32'(o_audio_select), 0);
        i_rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single request with hand-driven audio_end and exact timing.
        i_req     = 4'b0100;
        i_req_sel = 12'(5) << 6;
        expect_clip(2, 5, 1'b1);
        @(negedge clk);
        i_req = '0;
        @(posedge clk); #1;
        check("single_grant_n1", 32'(o_grant), 0);
        @(posedge clk); #1;
        check("single_grant_n2", 32'(o_grant), 32'h4);
        check("single_enable_n2", 32'(o_audio_enable), 1);
        check("single_select_n2", 32'(o_audio_select), 5);
        @(negedge clk);
        i_audio_end = 1'b0;
        repeat (6) @(negedge clk);
        check("single_busy_play", 32'(o_busy), 1);
        i_audio_end = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        check("single_done_e2", 32'(o_done), 0);
        check("single_enable_e2", 32'(o_audio_enable), 1);
        @(posedge clk); #1;
        check("single_done_e3", 32'(o_done), 32'h4);
        check("single_enable_e3", 32'(o_audio_enable), 0);
        repeat (GAP) @(posedge clk);
        #1;
        check("single_busy_gap", 32'(o_busy), 1);
        @(posedge clk); #1;
        check("single_busy_low", 32'(o_busy), 0);

        // Contention: all four at once, pointer back at 0 after reset.
        do_reset();
        g_auto = 1'b1;
        @(negedge clk);
        i_req     = 4'b1111;
        i_req_sel = {3'd4, 3'd3, 3'd2, 3'd1};
        for (int i = 0; i < 4; i++) expect_clip(i, i + 1, 1'b1);
        @(negedge clk);
        i_req = '0;
        wait_idle(600);

        // Fairness: 0 and 1 request continuously; latched repeats add two more.
        i_req     = 4'b0011;
        i_req_sel = {3'd0, 3'd0, 3'd2, 3'd1};
        for (int i = 0; i < 6; i++) expect_clip(i % 2, (i % 2) + 1, 1'b1);
        wait_grants(g_grant_cnt + 4, 600);
        i_req = '0;
        wait_idle(600);

        // Overwrite: requester 1 re-selects while clip 0 plays.
        i_req     = 4'b0001;
        i_req_sel = 12'd7;
        expect_clip(0, 7, 1'b1);
        expect_clip(1, 6, 1'b1);
        @(negedge clk);
        i_req = '0;
        wait_grants(g_grant_cnt + 1, 100);
        i_req     = 4'b0010;
        i_req_sel = 12'(2) << 3;
        @(negedge clk);
        i_req_sel = 12'(6) << 3;
        @(negedge clk);
        i_req = '0;
        wait_idle(600);

        // Hung audio block.
        g_hang    = 1'b1;
        i_req     = 4'b1000;
        i_req_sel = 12'(4) << 9;
`ifdef AUDIO_SCHED_WATCHDOG_EN
        expect_clip(3, 4, 1'b1);
`else
        expect_clip(3, 4, 1'b0);
`endif
        @(negedge clk);
        i_req = '0;
        wait_grants(g_grant_cnt + 1, 100);
        repeat (150) @(negedge clk);
`ifdef AUDIO_SCHED_WATCHDOG_EN
        check("wd_timeout", 32'(o_timeout), 1);
        check("wd_busy", 32'(o_busy), 0);
        check("wd_enable", 32'(o_audio_enable), 0);
`else
        check("hang_busy", 32'(o_busy), 1);
        check("hang_enable", 32'(o_audio_enable), 1);
        check("hang_timeout", 32'(o_timeout), 0);
        // Leave a pending request that reset must discard.
        i_req     = 4'b0010;
        i_req_sel = 12'(3) << 3;
        @(negedge clk);
        i_req = '0;
`endif

        // Reset mid-play.
        i_rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_grant", 32'(o_grant), 0);
        check("midrst_done", 32'(o_done), 0);
        check("midrst_busy", 32'(o_busy), 0);
        check("midrst_timeout", 32'(o_timeout), 0);
        check("midrst_enable", 32'(o_audio_enable), 0);
        check("midrst_select", 32'(o_audio_select), 0);
        @(negedge clk);
        i_rst = 1'b0;
        repeat (12) @(negedge clk);
        check("midrst_no_relaunch", 32'(o_busy), 0);

        check("grant_q_empty", 32'(grant_q.size()), 0);
        check("done_q_empty", 32'(done_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/audio_play_scheduler.md
# audio_play_scheduler

Sequences and shares the single `Audio` playback block between several game-side requesters (e.g. FSM event sounds, menu beeps, alarm). Latches one pending clip per requester, picks the next one round-robin, drives the audio block's `enable`/`audioSelect` pair, waits for `audioEnd`, and inserts a silence gap before the next clip. Sits between the game FSMs and the `Audio` instance.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `SEL_W`, 3: clip-select width; matches the audio block's `audioSelect`.
- `GAP_CYCLES`, 1000: idle cycles between consecutive clips (≥1).
- `TIMEOUT_CYCLES`, 400_000_000: watchdog limit per clip, in clk cycles.

- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  NUM_REQ  per-requester request strobe; sampled every cycle.
- `req_sel`  in  NUM_REQ*SEL_W  clip select of requester i at bits [i*SEL_W +: SEL_W].
- `grant`  out  NUM_REQ  one-hot, one-cycle pulse when requester's clip is launched.
- `done`  out  NUM_REQ  one-hot, one-cycle pulse when that clip finishes or is aborted.
- `busy`  out  1  high in any state other than IDLE.
- `timeout`  out  1  sticky; set on watchdog abort, cleared by `rst`.
- `audio_enable`  out  1  to audio block `enable`; registered, glitch-free.
- `audio_select`  out  SEL_W  to audio block `audioSelect`; stable while `audio_enable` high.
- `audio_end`  in  1  from audio block `audioEnd`; level, passed through a 2-flop synchronizer.

## Operation
- Pending table: `pend[i]` + `pend_sel[i]`. `req[i]`=1 sets `pend[i]` and loads `pend_sel[i]` (latest request overwrites an unlaunched one). Cleared on launch of i. Set and clear in same cycle: set wins, new select kept.
- Round-robin: pointer `rr` = index after last granted; search starts at `rr`, wraps at NUM_REQ. Reset `rr`=0.
- States:
  - IDLE: if any `pend`, pick winner w, load `audio_select`, go LAUNCH.
  - LAUNCH: `audio_enable`←1, `grant[w]` pulse, clear `pend[w]`, `rr`←w+1 mod NUM_REQ, go WAIT_LOW.
  - WAIT_LOW: wait synchronized `audio_end`=0 (block acknowledged start), go PLAY.
  - PLAY: wait synchronized `audio_end`=1; then `audio_enable`←0, `done[w]` pulse, go GAP.
  - GAP: count GAP_CYCLES, go IDLE.
- Requests during any state are latched; a requester may re-request its own playing clip (plays again after gap).
- Reset mid-playback: all state cleared next edge, `audio_enable` drops, no `done` pulse issued.

## Timing
- Reset values: `grant`=0, `done`=0, `busy`=0, `timeout`=0, `audio_enable`=0, `audio_select`=0.
- `req` at edge N (idle, gap elapsed) → `grant` and `audio_enable` rise at edge N+2.
- `audio_end` rise → `done` and `audio_enable` fall 3 edges later (2 sync + 1 register).
- `busy` rises with the IDLE→LAUNCH transition, falls on GAP→IDLE.
- Counter widths: `$clog2(GAP_CYCLES+1)`, `$clog2(TIMEOUT_CYCLES+1)`; saturate, never wrap.

## Configuration
- `AUDIO_SCHED_WATCHDOG_EN` defined: counter runs in WAIT_LOW and PLAY; on reaching TIMEOUT_CYCLES forces `audio_enable`←0, pulses `done[w]`, sets `timeout`, goes GAP.
- Undefined: no counter; scheduler waits on `audio_end` indefinitely; `timeout` tied 0.

## Structure
- Package `audio_sched_pkg`: state enum (IDLE, LAUNCH, WAIT_LOW, PLAY, GAP), default SEL_W constant.
- Sub-module `rr_picker`: combinational round-robin select (pend vector + pointer → winner index + valid).
- Synchronizer on `audio_end` inline (two flops).

## Test plan
- Single request: `req[2]`=1, `req_sel`=3'd5 → `grant`=4'b0100, `audio_select`=5 two cycles later; model `audio_end` 0 then 1 → `done`=4'b0100, then `busy` low GAP_CYCLES+1 later.
- Contention: `req`=4'b1111 same cycle → grants in order 0,1,2,3, one clip each, gaps between.
- Round-robin fairness: requesters 0 and 1 re-request continuously → grants alternate 0,1,0,1.
- Overwrite: `req[1]` sel 2 then sel 6 while clip 0 playing → requester 1 launches with `audio_select`=6, only one grant.
- Watchdog (macro on, TIMEOUT_CYCLES=100): `audio_end` held 0 → abort at 100 cycles, `done` pulse, `timeout`=1; macro off → stays in PLAY.
- Reset mid-PLAY: `rst` one cycle → next edge all outputs at reset values, pending cleared.
